ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the attached keyboard using the PS/2 request-to-send sequence, then checks the device's acknowledge bit. It shares the open-drain PS/2 clock and data pins with the scan-code receiver; top level gates the receiver with `busy` so host frames are not decoded as keystrokes.

---
 rtl/ps2_host_tx.sv | 172 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-clock frame, ACK check.
// Optional macro PS2_HOST_TX_RETRY_EN: retry a failed frame up to twice before reporting error.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned FIRST_TIMEOUT  = 750000,
   parameter int unsigned BIT_TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_async,
   input  logic       ps2_data_async,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RTS, WAIT_FIRST, SEND, WAIT_IDLE, FAIL
   } state_t;

   // INHIBIT lasts one cycle less than the hold; the RTS cycle completes it.
   localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 2);
   localparam logic [19:0] FIRST_TO = 20'(FIRST_TIMEOUT);
   localparam logic [19:0] BIT_TO   = 20'(BIT_TIMEOUT);

   state_t      state, state_nx;
   logic [1:0]  clk_sync, data_sync;
   logic        clk_prev;
   logic        fe;
   logic [19:0] cnt;
   logic [3:0]  edge_cnt;
   logic [3:0]  bit_idx;
   logic [9:0]  frame;
   logic        accept;
   logic        cnt_clr;
   logic        edge_set;
   logic        edge_inc;
   logic        fail;
   logic        done_set;
   logic        error_set;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0]  retry_cnt;
   logic        retry_inc;
`endif

   assign fe       = clk_prev & ~clk_sync[1];
   assign bit_idx  = edge_cnt - 4'd1;
   assign busy     = (state != IDLE);
   assign tx_ready = (state == IDLE) & ~done & ~error & ~rst;
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      state_nx  = state;
      cnt_clr   = 1'b0;
      edge_set  = 1'b0;
      edge_inc  = 1'b0;
      fail      = 1'b0;
      done_set  = 1'b0;
      error_set = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_inc = 1'b0;
`endif
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;

      case (state)
         IDLE: begin
            if (accept) state_nx = INHIBIT;
         end
         INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (cnt >= INH_LAST) state_nx = RTS;
         end
         RTS: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            state_nx    = WAIT_FIRST;
         end
         WAIT_FIRST: begin
            ps2_data_oe = 1'b1;
            if (fe) begin
               edge_set = 1'b1;
               state_nx = SEND;
            end else if (cnt >= FIRST_TO) begin
               fail = 1'b1;
            end
         end
         SEND: begin
            ps2_data_oe = ~frame[bit_idx];
            if (fe) begin
               cnt_clr = 1'b1;
               // The 11th falling edge carries the device's acknowledge.
               if (edge_cnt == 4'd10) begin
                  if (data_sync[1]) fail = 1'b1;
                  else              state_nx = WAIT_IDLE;
               end else begin
                  edge_inc = 1'b1;
               end
            end else if (cnt >= BIT_TO) begin
               fail = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync[1] && data_sync[1]) begin
               done_set = 1'b1;
               state_nx = IDLE;
            end else if (cnt >= BIT_TO) begin
               fail = 1'b1;
            end
         end
         FAIL: begin
            error_set = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      if (fail) begin
`ifdef PS2_HOST_TX_RETRY_EN
         if (retry_cnt != 2'd2) begin
            retry_inc = 1'b1;
            state_nx  = INHIBIT;
         end else begin
            state_nx  = FAIL;
         end
`else
         state_nx = FAIL;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
         cnt       <= '0;
         edge_cnt  <= '0;
         frame     <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nx;
         clk_sync  <= {clk_sync[0], ps2_clk_async};
         data_sync <= {data_sync[0], ps2_data_async};
         clk_prev  <= clk_sync[1];
         // Counter restarts on every state change and every device clock edge.
         if (state_nx != state || cnt_clr) cnt <= '0;
         else if (cnt != 20'hFFFFF)         cnt <= cnt + 20'd1;
         if (edge_set)      edge_cnt <= 4'd1;
         else if (edge_inc) edge_cnt <= edge_cnt + 4'd1;
         if (accept) frame <= {1'b1, ~^tx_data, tx_data};
         done  <= done_set;
         error <= error_set;
      end
   end

`ifdef PS2_HOST_TX_RETRY_EN
   always_ff @(posedge clk) begin
      if (rst)            retry_cnt <= '0;
      else if (accept)    retry_cnt <= '0;
      else if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
   end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard model and a frame scoreboard.
module tb_ps2_host_tx;
   localparam int INH  = 5000;
   localparam int FT   = 3000;
   localparam int BT   = 2000;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, error;
   logic       clk_pin, data_pin;

   assign clk_pin  = dev_clk & ~ps2_clk_oe;
   assign data_pin = dev_data & ~ps2_data_oe;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .FIRST_TIMEOUT(FT), .BIT_TIMEOUT(BT)) dut (
      .clk(clk), .rst(rst),
      .ps2_clk_async(clk_pin), .ps2_data_async(data_pin),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, done_cnt = 0, err_cnt = 0, inh_cnt = 0, run = 0, last_run = 0;
   int rts_cyc = 0, err_cyc = 0, acc_cnt = 0, viol = 0;
   logic [9:0] exp_q[$];
   logic [7:0] acc_q[$];

   always @(posedge clk) begin
      cyc++;
      if (tx_valid && tx_ready) begin
         acc_cnt++;
         acc_q.push_back(tx_data);
         exp_q.push_back({1'b1, ~^tx_data, tx_data});
      end
      if (tx_ready && busy) viol++;
   end

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (error) begin err_cnt++; err_cyc = cyc; end
      if (ps2_clk_oe && ps2_data_oe) rts_cyc = cyc;
      if (ps2_clk_oe) begin
         if (run == 0) inh_cnt++;
         run++;
      end else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation exceeded 95000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      int a0, t;
      a0 = acc_cnt; t = 0;
      @(negedge clk);
      tx_data = b; tx_valid = 1'b1;
      while (acc_cnt == a0 && t < 100) begin @(negedge clk); t++; end
      tx_valid = 1'b0;
   endtask

   // Keyboard model: waits for request-to-send, clocks 11 edges, samples on rising edges.
   task automatic device_frame(input bit ack, input int stop_after, output logic [9:0] bits, output bit ok);
      int t;
      bits = 'x; ok = 1'b0; t = 0;
      while (clk_pin !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
      t = 0;
      while (!(clk_pin === 1'b1 && data_pin === 1'b0) && t < 20000) begin @(negedge clk); t++; end
      if (t >= 20000) return;
      repeat (HALF) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         if (i == stop_after) return;
         if (i <= 10) bits[i-1] = data_pin;
         if (i == 10 && ack) dev_data = 1'b0;
         if (i == 11) dev_data = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      ok = 1'b1;
   endtask

   task automatic wait_result(input int target, input int limit);
      int t = 0;
      while (done_cnt + err_cnt < target && t < limit) begin @(negedge clk); t++; end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({ps2_clk_oe, ps2_data_oe, busy, tx_ready, done, error} !== 6'b0)
         $display("FAIL reset_outputs: got %b, want 000000", {ps2_clk_oe, ps2_data_oe, busy, tx_ready, done, error});
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b, want 1", tx_ready);
      else n_pass++;
   endtask

   task automatic test_frame(input logic [7:0] b, input logic [9:0] want);
      logic [9:0] bits, e;
      bit ok;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fork
         send(b);
         device_frame(1'b1, 0, bits, ok);
      join
      wait_result(d0 + e0 + 1, 2 * BT);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      n_chk++;
      if (bits !== want) $display("FAIL frame_bits_%h: got %h, want %h", b, bits, want);
      else n_pass++;
      n_chk++;
      if (bits !== e) $display("FAIL frame_scoreboard_%h: got %h, want %h", b, bits, e);
      else n_pass++;
      n_chk++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
         $display("FAIL frame_pulses_%h: done %0d error %0d, want done 1 error 0", b, done_cnt - d0, err_cnt - e0);
      else n_pass++;
      n_chk++;
      if (last_run !== INH) $display("FAIL inhibit_len_%h: got %0d, want %0d", b, last_run, INH);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int d0, e0, dt;
      d0 = done_cnt; e0 = err_cnt;
      send(8'hED);
      wait_result(d0 + e0 + 1, 3 * (INH + FT + 50));
      void'(exp_q.pop_front());
      dt = err_cyc - rts_cyc;
      n_chk++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
         $display("FAIL timeout_pulses: error %0d done %0d, want error 1 done 0", err_cnt - e0, done_cnt - d0);
      else n_pass++;
      n_chk++;
      if (dt < FT + 2 || dt > FT + 4) $display("FAIL timeout_latency: got %0d, want %0d+-1", dt, FT + 3);
      else n_pass++;
      n_chk++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) $display("FAIL timeout_release: got %b, want 00", {ps2_clk_oe, ps2_data_oe});
      else n_pass++;
   endtask

   task automatic test_nack();
      logic [9:0] bits, e;
      bit ok;
      int d0, e0, i0;
      d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
`ifdef PS2_HOST_TX_RETRY_EN
      fork
         send(8'hF4);
         begin
            device_frame(1'b0, 0, bits, ok);
            device_frame(1'b0, 0, bits, ok);
            device_frame(1'b1, 0, bits, ok);
         end
      join
      wait_result(d0 + e0 + 1, 2 * BT);
      n_chk++;
      if (inh_cnt - i0 !== 3) $display("FAIL nack_attempts: got %0d, want 3", inh_cnt - i0);
      else n_pass++;
      n_chk++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
         $display("FAIL nack_pulses: done %0d error %0d, want done 1 error 0", done_cnt - d0, err_cnt - e0);
      else n_pass++;
`else
      fork
         send(8'hF4);
         device_frame(1'b0, 0, bits, ok);
      join
      wait_result(d0 + e0 + 1, 2 * BT);
      n_chk++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0)
         $display("FAIL nack_pulses: error %0d done %0d, want error 1 done 0", err_cnt - e0, done_cnt - d0);
      else n_pass++;
      n_chk++;
      if (inh_cnt - i0 !== 1) $display("FAIL nack_attempts: got %0d, want 1", inh_cnt - i0);
      else n_pass++;
`endif
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      n_chk++;
      if (bits !== e) $display("FAIL nack_bits: got %h, want %h", bits, e);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [9:0] b1, b2, e1, e2;
      bit ok1, ok2;
      int d0, e0, a0, v0;
      d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt; v0 = viol;
      fork
         begin
            int t = 0;
            @(negedge clk);
            tx_data = 8'hFF; tx_valid = 1'b1;
            while (acc_cnt == a0 && t < 100) begin @(negedge clk); t++; end
            tx_data = 8'hF4;
            t = 0;
            while (acc_cnt < a0 + 2 && t < 20000) begin @(negedge clk); t++; end
            tx_valid = 1'b0;
         end
         begin
            device_frame(1'b1, 0, b1, ok1);
            device_frame(1'b1, 0, b2, ok2);
         end
      join
      wait_result(d0 + e0 + 2, 2 * BT);
      e1 = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      e2 = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
      n_chk++;
      if (acc_cnt - a0 !== 2) $display("FAIL b2b_accepts: got %0d, want 2", acc_cnt - a0);
      else n_pass++;
      n_chk++;
      if (acc_q.size() < 2 || acc_q[acc_q.size()-2] !== 8'hFF || acc_q[acc_q.size()-1] !== 8'hF4)
         $display("FAIL b2b_order: last accepted bytes differ from FF,F4");
      else n_pass++;
      n_chk++;
      if (b1 !== e1 || b1 !== 10'h3FF) $display("FAIL b2b_frame1: got %h, want %h", b1, 10'h3FF);
      else n_pass++;
      n_chk++;
      if (b2 !== e2 || b2 !== 10'h2F4) $display("FAIL b2b_frame2: got %h, want %h", b2, 10'h2F4);
      else n_pass++;
      n_chk++;
      if (viol - v0 !== 0 || done_cnt - d0 !== 2)
         $display("FAIL b2b_status: ready-while-busy %0d done %0d, want 0 and 2", viol - v0, done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [9:0] bits;
      bit ok;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      fork
         send(8'hED);
         device_frame(1'b1, 5, bits, ok);
      join
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000)
         $display("FAIL midreset_release: got %b, want 000", {ps2_clk_oe, ps2_data_oe, busy});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      repeat (200) @(negedge clk);
      n_chk++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
         $display("FAIL midreset_pulses: done %0d error %0d, want 0 0", done_cnt - d0, err_cnt - e0);
      else n_pass++;
      test_frame(8'hED, 10'h3ED);
   endtask

   initial begin
      test_reset();
      test_frame(8'hED, 10'h3ED);
      test_frame(8'h01, 10'h201);
      test_timeout();
      test_nack();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
